march_controller: RTL and testbench
===================================

// Module: march_controller
// PURPOSE
//  March C- sequencer for the memory BIST datapath. Sits directly upstream of address_generator:
//  drives its en/up_down/preset, consumes its address/carry, issues memory read/write ops.
//  Registers read compares and reports a sticky pass/fail with first-fail element and address.
// PARAMETERS
//  A_WIDTH  4  address width; must equal address_generator a_width; N = 2**A_WIDTH words
//  D_WIDTH  8  memory data width; backgrounds are all-0 / all-1 of D_WIDTH
// PORTS
//  clk           in   1        clock
//  reset         in   1        asynchronous, active-low reset
//  start         in   1        begin test; sampled only in IDLE or DONE
//  addr_en       out  1        step address_generator this cycle
//  addr_up_down  out  1        1 = ascending, 0 = descending
//  addr_preset   out  1        load start address (0 if up, N-1 if down)
//  addr_carry    in   1        generator at last address of current direction (combinational from address)
//  addr_in       in   A_WIDTH  current generator address (fail capture only)
//  mem_we        out  1        write strobe
//  mem_re        out  1        read strobe; mem_rdata valid exactly 1 cycle later
//  mem_wdata     out  D_WIDTH  write background
//  mem_rdata     in   D_WIDTH  read data
//  busy          out  1        high from PRESET through DRAIN
//  done          out  1        high in DONE until next accepted start
//  fail          out  1        sticky mismatch flag
//  fail_element  out  3        element index (0-5) of first mismatch
//  fail_addr     out  A_WIDTH  address of first mismatch
// BEHAVIOUR
//  - Reset (any time, incl. mid-test): state IDLE, every output 0; addr_up_down 1.
//  - Elements: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
//  - FSM IDLE -> PRESET -> RUN -> (PRESET for next element | DRAIN after E5) -> DONE.
//  - IDLE/DONE: start=1 -> PRESET; entering from DONE clears fail, fail_element, fail_addr, done.
//  - PRESET (1 cycle): addr_preset=1, addr_up_down = element direction; no mem strobes.
//  - RUN: one op per cycle, ops of an element issued in listed order per address.
//    addr_en=1 only on last op of an address; addr_up_down held for the element.
//    Last op with addr_carry=1: addr_en=0, element done -> PRESET(next) or DRAIN.
//  - Write op: mem_we=1, mem_wdata = background. Read op: mem_re=1, expected stored with element/address.
//  - Compare registered: rdata compared in cycle after mem_re; mismatch sets fail.
//    First mismatch only latches fail_element/fail_addr; later mismatches ignored.
//  - DRAIN (1 cycle): completes final E5 compare; no strobes. Then DONE, done=1.
//  - start ignored while busy. mem_we and mem_re never both high.
//  - Latency: done rises 10*N + 7 edges after edge sampling start (6 PRESET + 10N ops + DRAIN).
//  - Never addr_en and addr_preset in same cycle.
// STRUCTURE
//  - march_pkg: state enum; element index constants; op encoding (RD/WR, background bit);
//    element table (direction, op count, op list) as localparam function.
//  - One sub-module: march_compare (registered expected/valid/rdata compare, first-fail capture).
//  - Controller FSM + op/element counters stay in this module.
// TESTING
//  Bench instantiates march_controller + address_generator + behavioural 1-cycle-read RAM.
//  1 fault-free, A_WIDTH=4: pulse start -> done at edge 167, fail=0, 160 mem ops, 6 addr_preset pulses.
//  2 stuck-at-0 bit0 at addr 5 -> fail=1, fail_element=2, fail_addr=5; done still at edge 167.
//  3 direction: addr_up_down=0 during E3/E4 only; E3 first read addr 15, last read addr 0.
//  4 reset low mid-E2 -> all outputs 0 immediately; new start -> full clean run, done at 167.
//  5 start held/re-pulsed while busy -> ignored, done timing unchanged.
//  6 after failing run, start from DONE -> fail cleared next cycle; fault removed -> fail stays 0.

Source files
------------

// File: rtl/march_pkg.sv
// March C- shared definitions: FSM states, op encoding and the element table.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package march_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESET = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] ELEM_FIRST = 3'd0;
  localparam logic [2:0] ELEM_LAST  = 3'd5;

  // One memory op: write or read, plus the background bit (all-0 / all-1).
  typedef struct packed {
    logic wr;
    logic bg;
  } op_t;

  localparam op_t OP_R0 = '{wr: 1'b0, bg: 1'b0};
  localparam op_t OP_R1 = '{wr: 1'b0, bg: 1'b1};
  localparam op_t OP_W0 = '{wr: 1'b1, bg: 1'b0};
  localparam op_t OP_W1 = '{wr: 1'b1, bg: 1'b1};

  // Every element has one or two ops per address, so the op count is
  // carried as "index of the last op" in a single bit.
  typedef struct packed {
    logic up;
    logic last_op;
    op_t  op0;
    op_t  op1;
  } elem_t;

  function automatic elem_t elem_info(input logic [2:0] idx);
    elem_t e;
    case (idx)
      3'd0:    e = '{up: 1'b1, last_op: 1'b0, op0: OP_W0, op1: OP_W0};
      3'd1:    e = '{up: 1'b1, last_op: 1'b1, op0: OP_R0, op1: OP_W1};
      3'd2:    e = '{up: 1'b1, last_op: 1'b1, op0: OP_R1, op1: OP_W0};
      3'd3:    e = '{up: 1'b0, last_op: 1'b1, op0: OP_R0, op1: OP_W1};
      3'd4:    e = '{up: 1'b0, last_op: 1'b1, op0: OP_R1, op1: OP_W0};
      default: e = '{up: 1'b1, last_op: 1'b0, op0: OP_R0, op1: OP_R0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/march_compare.sv
// Read-data checker: registers the expected value of each read, compares it
// against memory data one cycle later, latches the first mismatch (sticky).
// Latency: fail rises on the edge ending the cycle after mem_re. No backpressure.
// Ports: rd_vld/rd_exp/rd_elem/rd_addr describe the read issued this cycle;
//        rdata arrives the next cycle; clear wipes the sticky result.
module march_compare
  import march_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               rd_vld,
  input  logic [D_WIDTH-1:0] rd_exp,
  input  logic [2:0]         rd_elem,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               fail,
  output logic [2:0]         fail_element,
  output logic [A_WIDTH-1:0] fail_addr
);

  logic               pend_vld;
  logic [D_WIDTH-1:0] pend_exp;
  logic [2:0]         pend_elem;
  logic [A_WIDTH-1:0] pend_addr;
  logic               mismatch;

  assign mismatch = pend_vld && (rdata != pend_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld  <= 1'b0;
      pend_exp  <= '0;
      pend_elem <= '0;
      pend_addr <= '0;
    end else begin
      pend_vld  <= rd_vld;
      pend_exp  <= rd_exp;
      pend_elem <= rd_elem;
      pend_addr <= rd_addr;
    end
  end

  // Only the first mismatch is recorded; later ones leave the capture alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail         <= 1'b0;
      fail_element <= '0;
      fail_addr    <= '0;
    end else if (clear) begin
      fail         <= 1'b0;
      fail_element <= '0;
      fail_addr    <= '0;
    end else if (mismatch && !fail) begin
      fail         <= 1'b1;
      fail_element <= pend_elem;
      fail_addr    <= pend_addr;
    end
  end

endmodule

// File: rtl/march_controller.sv
// March C- sequencer: drives address_generator, issues one memory op per cycle.
// Latency: done rises 10*N+7 edges after start is sampled. No backpressure; start ignored while busy.
// Ports: start in; addr_en/up_down/preset out, addr_carry/addr_in in; mem_we/re/wdata out,
//        mem_rdata in; busy/done/fail/fail_element/fail_addr status out.
module march_controller
  import march_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               addr_en,
  output logic               addr_up_down,
  output logic               addr_preset,
  input  logic               addr_carry,
  input  logic [A_WIDTH-1:0] addr_in,
  output logic               mem_we,
  output logic               mem_re,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [2:0]         fail_element,
  output logic [A_WIDTH-1:0] fail_addr
);

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         elem_idx;
  logic               op_idx;
  elem_t              cur;
  op_t                cur_op;
  logic               last_op;
  logic               start_ok;
  logic               rd_vld;
  logic [D_WIDTH-1:0] rd_exp;

  assign cur      = elem_info(elem_idx);
  assign cur_op   = op_idx ? cur.op1 : cur.op0;
  assign last_op  = (op_idx == cur.last_op);
  assign start_ok = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_PRESET;
      S_PRESET:       state_nxt = S_RUN;
      S_RUN: begin
        if (last_op && addr_carry)
          state_nxt = (elem_idx == ELEM_LAST) ? S_DRAIN : S_PRESET;
      end
      S_DRAIN:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Element / op counters. The element index advances on the final op of the
  // final address, so it already points at the next element during PRESET.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_idx <= ELEM_FIRST;
      op_idx   <= 1'b0;
    end else if (start_ok) begin
      elem_idx <= ELEM_FIRST;
      op_idx   <= 1'b0;
    end else if (state == S_RUN) begin
      if (last_op) begin
        op_idx <= 1'b0;
        if (addr_carry && (elem_idx != ELEM_LAST))
          elem_idx <= elem_idx + 3'd1;
      end else begin
        op_idx <= 1'b1;
      end
    end
  end

  always_comb begin
    addr_en      = 1'b0;
    addr_up_down = 1'b1;
    addr_preset  = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_wdata    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    rd_vld       = 1'b0;
    rd_exp       = {D_WIDTH{cur_op.bg}};
    case (state)
      S_PRESET: begin
        busy         = 1'b1;
        addr_preset  = 1'b1;
        addr_up_down = cur.up;
      end
      S_RUN: begin
        busy         = 1'b1;
        addr_up_down = cur.up;
        // Step only after the last op of an address, and never past the end:
        // the next element's PRESET reloads the generator instead.
        addr_en      = last_op && !addr_carry;
        if (cur_op.wr) begin
          mem_we    = 1'b1;
          mem_wdata = {D_WIDTH{cur_op.bg}};
        end else begin
          mem_re = 1'b1;
          rd_vld = 1'b1;
        end
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  march_compare #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_compare (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .rd_vld       (rd_vld),
    .rd_exp       (rd_exp),
    .rd_elem      (elem_idx),
    .rd_addr      (addr_in),
    .rdata        (mem_rdata),
    .fail         (fail),
    .fail_element (fail_element),
    .fail_addr    (fail_addr)
  );

endmodule

// File: tb/tb_march_controller.sv
// Bench: march_controller with a behavioural address generator and 1-cycle-read RAM
// with an injectable stuck-at bit. Expected op stream and run results come from a
// table-driven March C- model; a negedge monitor pops and compares them.
module tb_march_controller;

  localparam int A_WIDTH = 4;
  localparam int D_WIDTH = 8;
  localparam int N       = 1 << A_WIDTH;
  localparam int LAT     = 10 * N + 7;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               addr_en, addr_up_down, addr_preset, addr_carry;
  logic [A_WIDTH-1:0] gen_addr;
  logic               mem_we, mem_re;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               busy, done, fail;
  logic [2:0]         fail_element;
  logic [A_WIDTH-1:0] fail_addr;

  always #5 clk = ~clk;

  march_controller #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .addr_en(addr_en), .addr_up_down(addr_up_down), .addr_preset(addr_preset),
    .addr_carry(addr_carry), .addr_in(gen_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail),
    .fail_element(fail_element), .fail_addr(fail_addr)
  );

  // Address generator behaviour.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            gen_addr <= '0;
    else if (addr_preset)  gen_addr <= addr_up_down ? '0 : A_WIDTH'(N - 1);
    else if (addr_en)      gen_addr <= addr_up_down ? gen_addr + 1'b1 : gen_addr - 1'b1;
  end
  assign addr_carry = addr_up_down ? (gen_addr == A_WIDTH'(N - 1)) : (gen_addr == '0);

  // Fault injection: one stuck-at bit at one address, applied on write.
  bit       fault_on = 0;
  int       fault_addr = 0;
  int       fault_bit = 0;
  bit       fault_val = 0;

  function automatic logic [D_WIDTH-1:0] apply_fault(input int a, input logic [D_WIDTH-1:0] v);
    logic [D_WIDTH-1:0] r;
    r = v;
    if (fault_on && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  logic [D_WIDTH-1:0] ram [N];
  always @(posedge clk) begin
    if (mem_we) ram[gen_addr] <= apply_fault(int'(gen_addr), mem_wdata);
    if (mem_re) mem_rdata <= ram[gen_addr];
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // March C- as written: direction, op count, and per-op write flag / value.
  bit el_up   [6]    = '{1, 1, 1, 0, 0, 1};
  int el_nops [6]    = '{1, 2, 2, 2, 2, 1};
  bit el_wr   [6][2] = '{'{1, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit el_val  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  typedef struct {
    bit                 we;
    bit                 up;
    int                 addr;
    logic [D_WIDTH-1:0] wdata;
  } op_exp_t;

  typedef struct {
    int start_edge;
    bit fail;
    int felem;
    int faddr;
  } run_exp_t;

  op_exp_t  op_q [$];
  run_exp_t run_q [$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walk the algorithm over a model memory carrying the same fault.
  task automatic plan_run(input int st_edge);
    logic [D_WIDTH-1:0] m [N];
    run_exp_t r;
    op_exp_t  o;
    r = '{start_edge: st_edge, fail: 0, felem: 0, faddr: 0};
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        int a;
        a = el_up[e] ? k : N - 1 - k;
        for (int p = 0; p < el_nops[e]; p++) begin
          logic [D_WIDTH-1:0] v;
          v = el_val[e][p] ? {D_WIDTH{1'b1}} : {D_WIDTH{1'b0}};
          o = '{we: el_wr[e][p], up: el_up[e], addr: a, wdata: v};
          op_q.push_back(o);
          if (el_wr[e][p]) m[a] = apply_fault(a, v);
          else if (m[a] != v && !r.fail) begin
            r.fail = 1; r.felem = e; r.faddr = a;
          end
        end
      end
    end
    run_q.push_back(r);
  endtask

  // Monitor / scoreboard.
  int preset_cnt = 0;
  int op_cnt     = 0;
  bit done_q     = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      preset_cnt = 0;
      op_cnt     = 0;
      done_q     = 0;
    end else begin
      if (busy) check("strobe_exclusive", {addr_en & addr_preset, mem_we & mem_re}, 0);
      if (addr_preset) preset_cnt++;
      if (mem_we || mem_re) begin
        op_cnt++;
        if (op_q.size() == 0) begin
          check("unexpected_op", 1, 0);
        end else begin
          op_exp_t o;
          o = op_q.pop_front();
          check("op_we_re_dir_addr", {mem_we, mem_re, addr_up_down, 8'(gen_addr)},
                {o.we, !o.we, o.up, 8'(o.addr)});
          if (o.we) check("op_wdata", mem_wdata, o.wdata);
        end
      end
      if (done && !done_q) begin
        if (run_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          run_exp_t r;
          r = run_q.pop_front();
          check("done_latency", edge_cnt - r.start_edge, LAT);
          check("fail", fail, r.fail);
          check("fail_element", fail_element, r.fail ? r.felem : 0);
          check("fail_addr", fail_addr, r.fail ? r.faddr : 0);
          check("preset_pulses", preset_cnt, 6);
          check("mem_ops", op_cnt, 10 * N);
          check("ops_left", op_q.size(), 0);
        end
        preset_cnt = 0;
        op_cnt     = 0;
      end
      done_q = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_en"}, addr_en, 0);
    check({tag, "_addr_up_down"}, addr_up_down, 1);
    check({tag, "_addr_preset"}, addr_preset, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_fail_element"}, fail_element, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < LAT + 50 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      op_q.delete();
      run_q.delete();
    end
  endtask

  // Start a run: hold start for 'hold' cycles, optionally re-pulse while busy.
  task automatic do_run(input int hold, input int repulse_at);
    @(posedge clk); #1;
    start = 1'b1;
    plan_run(edge_cnt + 1);
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
    if (repulse_at > 0) begin
      repeat (repulse_at) @(posedge clk);
      #1 start = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fault-free run.
    do_run(1, 0);

    // Stuck-at-0 bit0 at address 5, start held and re-pulsed while busy.
    fault_on = 1; fault_addr = 5; fault_bit = 0; fault_val = 0;
    do_run(7, 60);
    check("sa0_fail", fail, 1);

    // Restart from DONE with the fault removed: sticky result clears at once.
    fault_on = 0;
    @(posedge clk); #1 start = 1'b1;
    plan_run(edge_cnt + 1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("restart_fail_cleared", fail, 0);
    check("restart_elem_cleared", fail_element, 0);
    check("restart_done_cleared", done, 0);
    check("restart_busy", busy, 1);
    wait_done();

    // Reset in the middle of E2 after a fault was already flagged in E1.
    fault_on = 1; fault_addr = $urandom_range(0, N - 1);
    fault_bit = $urandom_range(0, D_WIDTH - 1); fault_val = 1;
    @(posedge clk); #1 start = 1'b1;
    plan_run(edge_cnt + 1);
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 200 && preset_cnt < 3; i++) @(posedge clk);
    check("reached_e2", preset_cnt, 3);
    repeat ($urandom_range(2, 30)) @(posedge clk);
    #1 rst_n = 1'b0;
    op_q.delete();
    run_q.delete();
    #1 check_reset_outputs("midreset");
    fault_on = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_run(1, 0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      fault_on   = ($urandom_range(0, 2) != 0);
      fault_addr = $urandom_range(0, N - 1);
      fault_bit  = $urandom_range(0, D_WIDTH - 1);
      fault_val  = 1'($urandom_range(0, 1));
      do_run($urandom_range(1, 20), ($urandom_range(0, 1) != 0) ? $urandom_range(30, 100) : 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
